// File: rtl/mem_stage_access_ctrl.sv
// MEM-stage data-memory access controller: turns load/store controls into a req/ack bus
// transaction, stalls the pipeline while it runs, and returns extended load data.
module mem_stage_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        MemRead_MEM,
    input  logic        MemWrite_MEM,
    input  logic [1:0]  Mem_Size_MEM,
    input  logic        Mem_Unsigned_MEM,
    input  logic [31:0] ALU_Result_MEM,
    input  logic [31:0] Write_Data_MEM,
    output logic [31:0] Read_Data_MEM,
    output logic        Stall_MEM,
    output logic        Misaligned_Exc,
    output logic        Bus_Error,
    output logic        DMem_Req,
    output logic        DMem_We,
    output logic [31:0] DMem_Addr,
    output logic [3:0]  DMem_Be,
    output logic [31:0] DMem_Wdata,
    input  logic        DMem_Ack,
    input  logic [31:0] DMem_Rdata
);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             berr_q, berr_d;

    // Access attributes captured at request time so the bus and the load extract
    // stay consistent even if the inputs move during REQ.
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        ld_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  lane_q;

    logic        op, mis, start;
    logic        is_byte, is_half, is_word;
    logic [1:0]  lane;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [31:0] sh;
    logic [31:0] ld_ext;

    assign op      = MemRead_MEM | MemWrite_MEM;
    assign lane    = ALU_Result_MEM[1:0];
    assign is_byte = (Mem_Size_MEM == 2'b00);
    assign is_half = (Mem_Size_MEM == 2'b01);
    assign is_word = Mem_Size_MEM[1];
    assign mis     = (is_half & lane[0]) | (is_word & (lane != 2'b00));
    assign start   = (state_q == StIdle) & op & ~mis;

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = Write_Data_MEM;
        if (is_byte) begin
            be_new    = 4'b0001 << lane;
            wdata_new = {4{Write_Data_MEM[7:0]}};
        end else if (is_half) begin
            be_new    = 4'b0011 << lane;
            wdata_new = {2{Write_Data_MEM[15:0]}};
        end
    end

    assign sh = DMem_Rdata >> {lane_q, 3'b000};

    always_comb begin
        case (size_q)
            2'b00:   ld_ext = uns_q ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'b01:   ld_ext = uns_q ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: ld_ext = sh;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rdata_d        = rdata_q;
        berr_d         = berr_q;
        Stall_MEM      = 1'b0;
        Misaligned_Exc = 1'b0;
        DMem_Req       = 1'b0;
        case (state_q)
            StIdle: begin
                if (op) begin
                    if (mis) begin
                        Misaligned_Exc = 1'b1;
                        rdata_d        = 32'h0;
                    end else begin
                        Stall_MEM = 1'b1;
                        state_d   = StReq;
                    end
                end
            end
            StReq: begin
                DMem_Req  = 1'b1;
                Stall_MEM = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (DMem_Ack) begin
                    if (ld_q) begin
                        rdata_d = ld_ext;
                    end
                    cnt_d   = '0;
                    state_d = StDone;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    berr_d  = 1'b1;
                    rdata_d = 32'h0;
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                berr_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rdata_q <= 32'h0;
            berr_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            ld_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            lane_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            berr_q  <= berr_d;
            if (start) begin
                we_q    <= MemWrite_MEM & ~MemRead_MEM;
                addr_q  <= {ALU_Result_MEM[31:2], 2'b00};
                be_q    <= be_new;
                wdata_q <= wdata_new;
                ld_q    <= MemRead_MEM;
                size_q  <= Mem_Size_MEM;
                uns_q   <= Mem_Unsigned_MEM;
                lane_q  <= lane;
            end
        end
    end

    assign Read_Data_MEM = rdata_q;
    assign Bus_Error     = berr_q;
    assign DMem_We       = we_q;
    assign DMem_Addr     = addr_q;
    assign DMem_Be       = be_q;
    assign DMem_Wdata    = wdata_q;

endmodule

// File: tb/tb_mem_stage_access_ctrl.sv
// Directed bench for mem_stage_access_ctrl: one task per scenario, hand-computed expectations.
module tb_mem_stage_access_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        MemRead_MEM, MemWrite_MEM, Mem_Unsigned_MEM;
    logic [1:0]  Mem_Size_MEM;
    logic [31:0] ALU_Result_MEM, Write_Data_MEM;
    logic [31:0] Read_Data_MEM;
    logic        Stall_MEM, Misaligned_Exc, Bus_Error;
    logic        DMem_Req, DMem_We, DMem_Ack;
    logic [31:0] DMem_Addr, DMem_Wdata, DMem_Rdata;
    logic [3:0]  DMem_Be;

    int total = 0;
    int bad   = 0;

    // Observations from the last run_access call.
    int          n_stall, n_req;
    logic        done_seen, berr_done, bus_moved;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    mem_stage_access_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .Clk              (Clk),
        .Reset_n          (Reset_n),
        .MemRead_MEM      (MemRead_MEM),
        .MemWrite_MEM     (MemWrite_MEM),
        .Mem_Size_MEM     (Mem_Size_MEM),
        .Mem_Unsigned_MEM (Mem_Unsigned_MEM),
        .ALU_Result_MEM   (ALU_Result_MEM),
        .Write_Data_MEM   (Write_Data_MEM),
        .Read_Data_MEM    (Read_Data_MEM),
        .Stall_MEM        (Stall_MEM),
        .Misaligned_Exc   (Misaligned_Exc),
        .Bus_Error        (Bus_Error),
        .DMem_Req         (DMem_Req),
        .DMem_We          (DMem_We),
        .DMem_Addr        (DMem_Addr),
        .DMem_Be          (DMem_Be),
        .DMem_Wdata       (DMem_Wdata),
        .DMem_Ack         (DMem_Ack),
        .DMem_Rdata       (DMem_Rdata)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    task automatic set_op(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd);
        MemRead_MEM      = rd;
        MemWrite_MEM     = wr;
        Mem_Size_MEM     = sz;
        Mem_Unsigned_MEM = uns;
        ALU_Result_MEM   = addr;
        Write_Data_MEM   = wd;
    endtask

    task automatic clear_op();
        MemRead_MEM  = 1'b0;
        MemWrite_MEM = 1'b0;
    endtask

    // Call at a falling edge with the op already driven and the DUT idle. Acks on REQ cycle
    // ack_at (0 = never). Returns 1 ns into the DONE cycle with the op removed.
    task automatic run_access(input int ack_at, input logic [31:0] rdata);
        n_stall   = 0;
        n_req     = 0;
        done_seen = 1'b0;
        berr_done = 1'b0;
        bus_moved = 1'b0;
        for (int c = 0; c < 64; c++) begin
            #1;
            if (Stall_MEM) n_stall++;
            if (DMem_Req) begin
                n_req++;
                if (n_req == 1) begin
                    cap_addr  = DMem_Addr;
                    cap_be    = DMem_Be;
                    cap_we    = DMem_We;
                    cap_wdata = DMem_Wdata;
                end else if ({DMem_Addr, DMem_Be, DMem_We, DMem_Wdata} !==
                             {cap_addr, cap_be, cap_we, cap_wdata}) begin
                    bus_moved = 1'b1;
                end
                if (n_req == 2) begin
                    ALU_Result_MEM = ALU_Result_MEM ^ 32'hFFFF_FF00;
                    Write_Data_MEM = ~Write_Data_MEM;
                end
                if (n_req == ack_at) begin
                    DMem_Ack   = 1'b1;
                    DMem_Rdata = rdata;
                end else begin
                    DMem_Ack   = 1'b0;
                    DMem_Rdata = 32'h0;
                end
            end else if (n_req > 0) begin
                done_seen = 1'b1;
                berr_done = Bus_Error;
                DMem_Ack  = 1'b0;
                clear_op();
                break;
            end
            @(negedge Clk);
        end
    endtask

    task automatic test_reset();
        Reset_n    = 1'b0;
        DMem_Ack   = 1'b0;
        DMem_Rdata = 32'h0;
        set_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        @(negedge Clk);
        #1;
        total++;
        if ({Read_Data_MEM, Bus_Error, DMem_Req} !== 34'h0) begin
            bad++;
            $display("FAIL reset_regs: got rd=%h be=%b req=%b want 0", Read_Data_MEM, Bus_Error,
                     DMem_Req);
        end
        total++;
        if ({DMem_We, DMem_Addr, DMem_Be, DMem_Wdata, Stall_MEM} !== 70'h0) begin
            bad++;
            $display("FAIL reset_bus: got we=%b addr=%h be=%b wd=%h stall=%b want 0", DMem_We,
                     DMem_Addr, DMem_Be, DMem_Wdata, Stall_MEM);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_word_load();
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
        run_access(1, 32'hDEAD_BEEF);
        total++;
        if (!done_seen || n_stall != 2 || n_req != 1) begin
            bad++;
            $display("FAIL wload_timing: got done=%b stall=%0d req=%0d want 1/2/1", done_seen,
                     n_stall, n_req);
        end
        total++;
        if ({cap_addr, cap_be, cap_we} !== {32'h0000_0010, 4'b1111, 1'b0}) begin
            bad++;
            $display("FAIL wload_bus: got addr=%h be=%b we=%b want 00000010/1111/0", cap_addr,
                     cap_be, cap_we);
        end
        total++;
        if (Read_Data_MEM !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL wload_data: got %h want deadbeef", Read_Data_MEM);
        end
        @(negedge Clk);
        #1;
        total++;
        if ({Stall_MEM, DMem_Req} !== 2'b00) begin
            bad++;
            $display("FAIL wload_idle: got stall=%b req=%b want 0/0", Stall_MEM, DMem_Req);
        end
        @(negedge Clk);
    endtask

    task automatic test_byte_load();
        set_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0);
        run_access(1, 32'h80FF_0000);
        total++;
        if (cap_be !== 4'b1000 || cap_addr !== 32'h0000_0010) begin
            bad++;
            $display("FAIL sbyte_bus: got be=%b addr=%h want 1000/00000010", cap_be, cap_addr);
        end
        total++;
        if (Read_Data_MEM !== 32'hFFFF_FF80) begin
            bad++;
            $display("FAIL sbyte_data: got %h want ffffff80", Read_Data_MEM);
        end
        @(negedge Clk);
        set_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0);
        run_access(1, 32'h80FF_0000);
        total++;
        if (Read_Data_MEM !== 32'h0000_0080) begin
            bad++;
            $display("FAIL ubyte_data: got %h want 00000080", Read_Data_MEM);
        end
        @(negedge Clk);
    endtask

    task automatic test_half_store();
        set_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h1234_ABCD);
        run_access(4, 32'hFFFF_FFFF);
        total++;
        if (!done_seen || n_stall != 5 || n_req != 4) begin
            bad++;
            $display("FAIL hstore_timing: got done=%b stall=%0d req=%0d want 1/5/4", done_seen,
                     n_stall, n_req);
        end
        total++;
        if ({cap_we, cap_be, cap_addr} !== {1'b1, 4'b1100, 32'h0000_0020}) begin
            bad++;
            $display("FAIL hstore_bus: got we=%b be=%b addr=%h want 1/1100/00000020", cap_we,
                     cap_be, cap_addr);
        end
        total++;
        if (cap_wdata !== 32'hABCD_ABCD) begin
            bad++;
            $display("FAIL hstore_wdata: got %h want abcdabcd", cap_wdata);
        end
        total++;
        if (bus_moved !== 1'b0) begin
            bad++;
            $display("FAIL hstore_hold: got bus_moved=%b want 0", bus_moved);
        end
        total++;
        if (Read_Data_MEM !== 32'h0000_0080) begin
            bad++;
            $display("FAIL hstore_rdata: got %h want 00000080", Read_Data_MEM);
        end
        @(negedge Clk);
    endtask

    task automatic test_timeout();
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0);
        run_access(0, 32'h0);
        total++;
        if (!done_seen || n_req != 16 || n_stall != 17) begin
            bad++;
            $display("FAIL timeout_len: got done=%b req=%0d stall=%0d want 1/16/17", done_seen,
                     n_req, n_stall);
        end
        total++;
        if (berr_done !== 1'b1 || Read_Data_MEM !== 32'h0) begin
            bad++;
            $display("FAIL timeout_err: got berr=%b rd=%h want 1/00000000", berr_done,
                     Read_Data_MEM);
        end
        total++;
        if (bus_moved !== 1'b0) begin
            bad++;
            $display("FAIL timeout_hold: got bus_moved=%b want 0", bus_moved);
        end
        @(negedge Clk);
        #1;
        total++;
        if ({Bus_Error, DMem_Req, Stall_MEM} !== 3'b000) begin
            bad++;
            $display("FAIL timeout_idle: got berr=%b req=%b stall=%b want 000", Bus_Error,
                     DMem_Req, Stall_MEM);
        end
        @(negedge Clk);
    endtask

    task automatic test_misaligned();
        logic [1:0] sz_t  [6] = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd3, 2'd0};
        logic [1:0] lo_t  [6] = '{2'd2, 2'd0, 2'd1, 2'd2, 2'd1, 2'd3};
        logic       mis_t [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            set_op(1'b1, 1'b0, sz_t[i], 1'b0, {30'h0000_0040, lo_t[i]}, 32'h0);
            #1;
            total++;
            if (Misaligned_Exc !== mis_t[i] || Stall_MEM !== ~mis_t[i]) begin
                bad++;
                $display("FAIL mis_decode[%0d]: got mis=%b stall=%b want %b/%b", i,
                         Misaligned_Exc, Stall_MEM, mis_t[i], ~mis_t[i]);
            end
            clear_op();
            @(negedge Clk);
        end
        // Put non-zero data in the load register so the clear on misalign is visible.
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0);
        run_access(1, 32'h5555_AAAA);
        @(negedge Clk);
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0);
        #1;
        total++;
        if ({Misaligned_Exc, Stall_MEM, DMem_Req} !== 3'b100) begin
            bad++;
            $display("FAIL mis_word: got mis=%b stall=%b req=%b want 100", Misaligned_Exc,
                     Stall_MEM, DMem_Req);
        end
        @(negedge Clk);
        #1;
        total++;
        if (DMem_Req !== 1'b0 || Read_Data_MEM !== 32'h0) begin
            bad++;
            $display("FAIL mis_word_rd: got req=%b rd=%h want 0/00000000", DMem_Req,
                     Read_Data_MEM);
        end
        set_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0003, 32'h0);
        @(negedge Clk);
        #1;
        total++;
        if ({Misaligned_Exc, Stall_MEM, DMem_Req} !== 3'b100 || Read_Data_MEM !== 32'h0) begin
            bad++;
            $display("FAIL mis_half: got mis=%b stall=%b req=%b rd=%h want 100/00000000",
                     Misaligned_Exc, Stall_MEM, DMem_Req, Read_Data_MEM);
        end
        clear_op();
        @(negedge Clk);
    endtask

    task automatic test_back_to_back();
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
        run_access(1, 32'h1111_2222);
        total++;
        if (Read_Data_MEM !== 32'h1111_2222 || n_stall != 2) begin
            bad++;
            $display("FAIL b2b_first: got rd=%h stall=%0d want 11112222/2", Read_Data_MEM,
                     n_stall);
        end
        set_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0106, 32'h0);
        @(negedge Clk);
        run_access(1, 32'h8765_4321);
        total++;
        if (!done_seen || n_stall != 2 || cap_be !== 4'b1100 || cap_addr !== 32'h0000_0104) begin
            bad++;
            $display("FAIL b2b_second: got done=%b stall=%0d be=%b addr=%h want 1/2/1100/00000104",
                     done_seen, n_stall, cap_be, cap_addr);
        end
        total++;
        if (Read_Data_MEM !== 32'h0000_8765) begin
            bad++;
            $display("FAIL b2b_data: got %h want 00008765", Read_Data_MEM);
        end
        @(negedge Clk);
    endtask

    task automatic test_reset_mid_access();
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'h0);
        @(negedge Clk);
        @(negedge Clk);
        #1;
        total++;
        if (DMem_Req !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_pre: got req=%b want 1", DMem_Req);
        end
        Reset_n = 1'b0;
        clear_op();
        #1;
        total++;
        if ({DMem_Req, Stall_MEM, Bus_Error, Read_Data_MEM} !== 35'h0) begin
            bad++;
            $display("FAIL rst_mid_out: got req=%b stall=%b berr=%b rd=%h want 0", DMem_Req,
                     Stall_MEM, Bus_Error, Read_Data_MEM);
        end
        total++;
        if ({DMem_We, DMem_Addr, DMem_Be, DMem_Wdata} !== 69'h0) begin
            bad++;
            $display("FAIL rst_mid_bus: got we=%b addr=%h be=%b wd=%h want 0", DMem_We,
                     DMem_Addr, DMem_Be, DMem_Wdata);
        end
        @(negedge Clk);
        DMem_Ack   = 1'b1;
        DMem_Rdata = 32'hFFFF_FFFF;
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        #1;
        total++;
        if ({DMem_Req, Stall_MEM, Read_Data_MEM} !== 34'h0) begin
            bad++;
            $display("FAIL rst_mid_after: got req=%b stall=%b rd=%h want 0", DMem_Req,
                     Stall_MEM, Read_Data_MEM);
        end
        DMem_Ack = 1'b0;
        @(negedge Clk);
        #1;
        total++;
        if ({DMem_Req, Bus_Error, Read_Data_MEM} !== 34'h0) begin
            bad++;
            $display("FAIL rst_mid_idle: got req=%b berr=%b rd=%h want 0", DMem_Req, Bus_Error,
                     Read_Data_MEM);
        end
        @(negedge Clk);
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_load();
        test_half_store();
        test_timeout();
        test_misaligned();
        test_back_to_back();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_access_ctrl.md
Name: mem_stage_access_ctrl

Overview:
MEM-stage data-memory access controller. It sits between the EX/MEM register outputs and the MEM/WB pipeline register.
- Converts load/store control plus the ALU-computed address into a req/ack transaction on the data-memory bus.
- Stalls the pipeline until the access completes.
- Returns byte/half/word load data, sign- or zero-extended, as Read_Data_MEM for the MEM/WB register.

Parameters:
TIMEOUT_CYCLES, 16, max cycles in REQ without DMem_Ack before the access is aborted with Bus_Error
CNT_W, 5, width of timeout counter; must hold TIMEOUT_CYCLES

Ports:
Clk  input  1  pipeline clock, rising edge
Reset_n  input  1  asynchronous, active-low reset
MemRead_MEM  input  1  load in MEM stage
MemWrite_MEM  input  1  store in MEM stage (MemRead_MEM has priority if both set)
Mem_Size_MEM  input  2  00 byte, 01 half, 10/11 word
Mem_Unsigned_MEM  input  1  1 = zero-extend load, 0 = sign-extend
ALU_Result_MEM  input  32  byte address
Write_Data_MEM  input  32  store data (low bits used for byte/half)
Read_Data_MEM  output  32  extended load data, registered
Stall_MEM  output  1  hold PC/IF-ID/ID-EX/EX-MEM; suppress MEM/WB capture
Misaligned_Exc  output  1  combinational; misaligned access detected
Bus_Error  output  1  registered; access timed out
DMem_Req  output  1  bus request
DMem_We  output  1  1 = write
DMem_Addr  output  32  word-aligned address {addr[31:2],2'b00}
DMem_Be  output  4  byte enables
DMem_Wdata  output  32  lane-replicated store data
DMem_Ack  input  1  access complete; DMem_Rdata valid same cycle
DMem_Rdata  input  32  read word

Behaviour:
- Reset (Reset_n=0, async):
  - State IDLE.
  - Read_Data_MEM, Bus_Error, timeout counter, DMem_Req, DMem_We, DMem_Addr, DMem_Be and DMem_Wdata all 0.
  - An in-flight access is abandoned; any later Ack is ignored.
- op = MemRead_MEM | MemWrite_MEM.
- mis = (half & addr[0]) | (word & addr[1:0]!=0).
- States: IDLE, REQ, DONE.
- IDLE:
  - op & !mis:
    - Stall_MEM=1 (combinational).
    - Latch DMem_We/Addr/Be/Wdata; next state REQ.
  - op & mis:
    - Misaligned_Exc=1, Stall_MEM=0.
    - No bus request; store is suppressed; Read_Data_MEM <= 0; stay IDLE.
  - !op: Stall_MEM=0; stay IDLE.
- REQ:
  - DMem_Req=1 and Stall_MEM=1; bus outputs held stable.
  - Counter increments each cycle.
  - Ack=1:
    - Loads capture extended data into Read_Data_MEM.
    - Stores leave Read_Data_MEM unchanged.
    - Clear counter; next state DONE.
  - Counter reaches TIMEOUT_CYCLES-1 with Ack=0:
    - Bus_Error <= 1, Read_Data_MEM <= 0.
    - Next state DONE.
- DONE:
  - DMem_Req=0, Stall_MEM=0; MEM/WB captures at the end of this cycle.
  - Next state IDLE; Bus_Error <= 0 on leaving DONE (1-cycle pulse).
- Latency: a memory op with Ack in its first REQ cycle occupies 3 cycles (IDLE, REQ, DONE) with 2 stall cycles; each extra wait cycle adds 1.
- Back-to-back memory ops: the next op starts in IDLE the cycle after DONE.
- DMem_Ack outside REQ is ignored.
- Byte lanes are little-endian; lane = addr[1:0].
  - Byte: Be = 4'b0001 << lane; Wdata = {4{wd[7:0]}}.
  - Half: Be = 4'b0011 << lane; Wdata = {2{wd[15:0]}}.
  - Word: Be = 4'b1111; Wdata = wd.
  - Loads: Be as above, We=0.
- Load extract:
  - sh = DMem_Rdata >> (8*lane).
  - Byte: extend sh[7:0] by Mem_Unsigned_MEM.
  - Half: extend sh[15:0] by Mem_Unsigned_MEM.
  - Word: full 32 bits.
- Inputs are stable for the whole access because EX/MEM is held by Stall_MEM. A change in the inputs during REQ does not alter the latched bus outputs.

Test Plan:
- Word load, addr 0x0000_0010, Ack on the first REQ cycle, Rdata 0xDEAD_BEEF -> DMem_Addr=0x10, Be=1111, We=0; Stall_MEM high 2 cycles; Read_Data_MEM=0xDEAD_BEEF in DONE.
- Signed byte load, addr 0x...13, Rdata 0x80FF_0000 -> Be=1000, Read_Data_MEM=0xFFFF_FF80. Same access with Mem_Unsigned_MEM=1 -> 0x0000_0080.
- Half store, addr 0x...22, wd 0x1234_ABCD, Ack after 3 wait cycles -> DMem_We=1, Be=1100, Wdata=0xABCD_ABCD; Stall_MEM high 5 cycles; Read_Data_MEM unchanged.
- Word load at addr 0x...06 -> Misaligned_Exc=1, Stall_MEM=0, DMem_Req never asserted, Read_Data_MEM=0. Half load at 0x...03 -> the same.
- Load with no Ack, TIMEOUT_CYCLES=16 -> Req high exactly 16 cycles; Bus_Error pulses 1 cycle in DONE; Read_Data_MEM=0; return to IDLE.
- Reset_n pulled low in the 2nd REQ cycle, Ack asserted 1 cycle later -> DMem_Req drops immediately, all outputs 0, state IDLE. After release with op=0, no request is issued.
